reg_bank_wb: RTL

- 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath.
- Write-side consumer of the register-destination select: takes the 32-bit selected destination index (rt, rd, 29, rs or 31) plus write data.
- Serves two combinational read ports (rs, rt) to the A/B operand registers.
- Enforces the $zero, $sp-reset and index-range rules in one place.

---
 rtl/cpu_regs_pkg.sv | 15 +
 rtl/reg_bank_wb_rdport.sv | 21 ++
 rtl/reg_bank_wb.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared MIPS register-file constants, also used by the register-destination select.
package cpu_regs_pkg;

  localparam int                   REG_IDX_W    = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO     = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP       = 5'd29;
  localparam logic [REG_IDX_W-1:0] REG_RA       = 5'd31;
  localparam logic [31:0]          SP_RESET_VAL = 32'd227;

  // The destination select hands over a full word; only the low bits may be set.
  function automatic logic dest_in_range(input logic [31:0] dest);
    return dest[31:REG_IDX_W] == '0;
  endfunction

endpackage

// File: rtl/reg_bank_wb_rdport.sv
// One combinational read port: $zero forcing plus optional write-through data.
module reg_bank_wb_rdport
  import cpu_regs_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic [31:0]          arr_word,
  input  logic                 byp_hit,
  input  logic [31:0]          byp_data,
  output logic [31:0]          rd_data
);

  always_comb begin
    rd_data = arr_word;
    if (byp_hit) begin
      rd_data = byp_data;
    end else if (rd_idx == REG_ZERO) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_bank_wb.sv
// 32x32 MIPS register bank with two async read ports and one checked write port.
// Define REG_BANK_WB_BYPASS_EN for same-cycle write-through on the read ports.
module reg_bank_wb
  import cpu_regs_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_VAL,
  parameter int          NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] read_reg1,
  input  logic [REG_IDX_W-1:0] read_reg2,
  input  logic [31:0]          write_reg,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data1,
  output logic [31:0]          read_data2,
  output logic                 wr_addr_err,
  output logic [REG_IDX_W-1:0] last_wr_reg
);

  logic [31:0]          regs_q [NUM_REGS];
  logic [31:0]          regs_d [NUM_REGS];
  logic                 wr_addr_err_q, wr_addr_err_d;
  logic [REG_IDX_W-1:0] last_wr_reg_q, last_wr_reg_d;

  logic [REG_IDX_W-1:0] wr_idx;
  logic                 wr_in_range;
  logic                 wr_commit;
  logic                 byp_hit1, byp_hit2;

  assign wr_idx      = write_reg[REG_IDX_W-1:0];
  assign wr_in_range = dest_in_range(write_reg);
  assign wr_commit   = reg_write && wr_in_range && (wr_idx != REG_ZERO);

  always_comb begin
    regs_d        = regs_q;
    wr_addr_err_d = wr_addr_err_q;
    last_wr_reg_d = last_wr_reg_q;
    if (reg_write) begin
      if (!wr_in_range) begin
        wr_addr_err_d = 1'b1;
      end else begin
        // A $zero write still updates last_wr_reg (to 0) but never the array.
        last_wr_reg_d = wr_idx;
        if (wr_commit) begin
          regs_d[wr_idx] = write_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (REG_IDX_W'(i) == REG_SP) ? SP_RESET : '0;
      end
      wr_addr_err_q <= 1'b0;
      last_wr_reg_q <= REG_ZERO;
    end else begin
      regs_q        <= regs_d;
      wr_addr_err_q <= wr_addr_err_d;
      last_wr_reg_q <= last_wr_reg_d;
    end
  end

`ifdef REG_BANK_WB_BYPASS_EN
  assign byp_hit1 = wr_commit && (read_reg1 == wr_idx);
  assign byp_hit2 = wr_commit && (read_reg2 == wr_idx);
`else
  assign byp_hit1 = 1'b0;
  assign byp_hit2 = 1'b0;
`endif

  reg_bank_wb_rdport u_rdport1 (
    .rd_idx   (read_reg1),
    .arr_word (regs_q[read_reg1]),
    .byp_hit  (byp_hit1),
    .byp_data (write_data),
    .rd_data  (read_data1)
  );

  reg_bank_wb_rdport u_rdport2 (
    .rd_idx   (read_reg2),
    .arr_word (regs_q[read_reg2]),
    .byp_hit  (byp_hit2),
    .byp_data (write_data),
    .rd_data  (read_data2)
  );

  assign wr_addr_err = wr_addr_err_q;
  assign last_wr_reg = last_wr_reg_q;

endmodule
